// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with a one-deep output holding stage.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9), LSB first on the line
//   OVERSAMPLE  s_tick pulses per bit time (even, 8..64)
//   PARITY_MODE 0 none, 1 even, 2 odd
//   STOP_BITS   stop bits checked (1..2)
//
// Ports:
//   clk, rstN   rising-edge clock, asynchronous active-low reset
//   enabled     receiver enable; low aborts any frame in progress
//   in          asynchronous rx line, idle high
//   s_tick      one-clk oversample strobe
//   rdy         consumer ready; valid & rdy transfers the held frame
//   valid       out/flags hold an unconsumed frame
//   out         received data
//   parity_err, frame_err, break_det   per-frame status, qualified by valid
//   overrun     sticky: a frame was dropped because valid was held
//   busy        frame in progress
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to replace each single
// centre sample with a 2-of-3 vote over the last three ticks.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 enabled,
    input  logic                 in,
    input  logic                 s_tick,
    input  logic                 rdy,
    output logic                 valid,
    output logic [DATA_BITS-1:0] out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SW-1:0]          s;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic                   armed;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   done;
    logic                   res_perr, res_ferr, res_brk;
    logic                   sync1, line;
    logic                   prev_line;
    logic                   sample;
    logic                   perr_calc;

    // Two-flop synchroniser; resets to the idle (high) level.
    // NOTE: every clocked block uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= in;
            line  <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic prev2_line;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prev_line  <= 1'b0;
            prev2_line <= 1'b0;
        end else if (s_tick) begin
            prev_line  <= line;
            prev2_line <= prev_line;
        end
    end

    assign sample = (prev2_line & prev_line) | (prev2_line & line) | (prev_line & line);
`else
    // Line level at the previous tick; resets low so the reset value of the
    // synchroniser can never arm the receiver on its own.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) prev_line <= 1'b0;
        else if (s_tick) prev_line <= line;
    end

    assign sample = line;
`endif

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY_MODE == 1) perr_calc = (^shreg) ^ par_bit;
        else if (PARITY_MODE == 2) perr_calc = ~((^shreg) ^ par_bit);
    end

    // Receive FSM. Armed means the line was high on two consecutive ticks
    // since the last frame ended, so a held-low line (break, reset mid-frame)
    // cannot start a new frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            s        <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            armed    <= 1'b0;
            busy     <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            done     <= 1'b0;
            res_perr <= 1'b0;
            res_ferr <= 1'b0;
            res_brk  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!enabled) begin
                state    <= IDLE;
                s        <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                busy     <= 1'b0;
                armed    <= 1'b0;
            end else if (s_tick) begin
                case (state)
                    IDLE: begin
                        if (line && prev_line) begin
                            armed <= 1'b1;
                        end else if (armed && !line) begin
                            state <= START;
                            s     <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (s == S_MID) begin
                            s <= '0;
                            if (sample) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    DATA: begin
                        if (s == S_END) begin
                            s     <= '0;
                            shreg <= {sample, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == B_LAST) begin
                                state    <= (PARITY_MODE != 0) ? PARITY : STOP;
                                stop_cnt <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (s == S_END) begin
                            s        <= '0;
                            par_bit  <= sample;
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    STOP: begin
                        if (s == S_END) begin
                            s <= '0;
                            // A low stop bit ends the frame immediately.
                            if (!sample || stop_cnt == STOP_LAST) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                armed    <= 1'b0;
                                done     <= 1'b1;
                                res_perr <= perr_calc;
                                res_ferr <= !sample;
                                res_brk  <= !sample && !stop_cnt && (shreg == '0) &&
                                            (PARITY_MODE == 0 || !par_bit);
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                    // NOTE: a default arm recovers from unreachable encodings.
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output holding stage: loads one clk after the final stop sample.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid      <= 1'b0;
            out        <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!valid || rdy) begin
                valid      <= 1'b1;
                out        <= shreg;
                parity_err <= res_perr;
                frame_err  <= res_ferr;
                break_det  <= res_brk;
                if (valid) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && rdy) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- self-checking bench for uart_rx_param.
// Three receivers share the line: 8N1 (index 0), 8E1 (index 1), 8O2 (index 2).
// Expected results come from a frame-level model working on bit-period levels.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rstN, enabled, line, s_tick, rdy;
    logic [2:0] valid_v, perr_v, ferr_v, brk_v, ovr_v, busy_v;
    logic [7:0] out_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rstN(rstN), .enabled(enabled), .in(line), .s_tick(s_tick), .rdy(rdy),
        .valid(valid_v[0]), .out(out_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
        .break_det(brk_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rstN(rstN), .enabled(enabled), .in(line), .s_tick(s_tick), .rdy(rdy),
        .valid(valid_v[1]), .out(out_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
        .break_det(brk_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .rstN(rstN), .enabled(enabled), .in(line), .s_tick(s_tick), .rdy(rdy),
        .valid(valid_v[2]), .out(out_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
        .break_det(brk_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]));

    initial forever #5 clk = ~clk;

    // One-clk tick every fourth clock.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Frame-level model: f[i] is the line level during bit period i (0 = start).
    function automatic exp_t ref_model(input logic [15:0] f, input int pm, input int sb);
        exp_t e;
        int   idx;
        logic pb;
        e.data = f[8:1];
        idx    = 9;
        pb     = 1'b0;
        if (pm != 0) begin
            pb  = f[9];
            idx = 10;
        end
        e.perr = (pm == 1) ? (((^e.data) ^ pb) == 1'b1) :
                 (pm == 2) ? (((^e.data) ^ pb) == 1'b0) : 1'b0;
        e.ferr = (f[idx] == 1'b0) || (sb == 2 && f[idx+1] == 1'b0);
        e.brk  = (e.data == 8'h00) && (pm == 0 || pb == 1'b0) && (f[idx] == 1'b0);
        return e;
    endfunction

    function automatic logic [15:0] mk8n1(input logic [7:0] d);
        return {6'h3F, 1'b1, d, 1'b0};
    endfunction

    // Wait for n ticks, then step 1 ns past the edge so new drives do not race it.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    // Drive nbits bit periods of f; glitch_bit inverts one tick near the centre.
    task automatic send_bits(input logic [15:0] f, input int nbits, input int glitch_bit);
        wait_ticks(1);
        for (int i = 0; i < nbits; i++) begin
            line = f[i];
            if (i == glitch_bit) begin
                wait_ticks(8);
                line = ~f[i];
                wait_ticks(1);
                line = f[i];
                wait_ticks(OS - 9);
            end else begin
                wait_ticks(OS);
            end
        end
        line = 1'b1;
    endtask

    task automatic do_reset();
        rstN    = 1'b0;
        enabled = 1'b1;
        rdy     = 1'b0;
        line    = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        wait_ticks(4);
    endtask

    task automatic pulse_rdy();
        @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int k, input exp_t e);
        check({tag, "_valid"}, valid_v[k], 1'b1);
        check({tag, "_out"},   out_v[k],   e.data);
        check({tag, "_perr"},  perr_v[k],  e.perr);
        check({tag, "_ferr"},  ferr_v[k],  e.ferr);
        check({tag, "_brk"},   brk_v[k],   e.brk);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] f;
        logic [7:0]  d;

        // Reset state.
        rstN = 1'b0; enabled = 1'b1; rdy = 1'b0; line = 1'b1;
        #23;
        check("rst_valid", valid_v[0], 1'b0);
        check("rst_out",   out_v[0],   8'h00);
        check("rst_perr",  perr_v[0],  1'b0);
        check("rst_ferr",  ferr_v[0],  1'b0);
        check("rst_brk",   brk_v[0],   1'b0);
        check("rst_ovr",   ovr_v[0],   1'b0);
        check("rst_busy",  busy_v[0],  1'b0);

        // 8N1 0xA5 with rdy high: one valid pulse, busy for 9.5 bit times.
        do_reset();
        rdy = 1'b1;
        fork
            send_bits(mk8n1(8'hA5), 10, -1);
            begin
                int nv = 0, nb = 0;
                logic [7:0] cap = 8'h00;
                logic [2:0] flg = 3'b111;
                repeat (12 * OS * 4) begin
                    @(negedge clk);
                    if (valid_v[0]) begin
                        nv++;
                        cap = out_v[0];
                        flg = {perr_v[0], ferr_v[0], brk_v[0]};
                    end
                    if (busy_v[0]) nb++;
                end
                check("a5_pulses", nv, 1);
                check("a5_out", cap, 8'hA5);
                check("a5_flags", flg, 3'b000);
                // Start seen one tick after the fall; last stop sample 152 ticks later.
                check("a5_busy_clks", nb, 152 * 4);
            end
        join
        rdy = 1'b0;
        check("a5_busy_end", busy_v[0], 1'b0);

        // 0x3C with parity bit 1: even -> error, odd -> no error.
        do_reset();
        send_bits({4'hF, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12, -1);
        wait_ticks(OS);
        check("even_valid", valid_v[1], 1'b1);
        check("even_out",   out_v[1],   8'h3C);
        check("even_perr",  perr_v[1],  1'b1);
        check("even_ferr",  ferr_v[1],  1'b0);
        check("odd_valid",  valid_v[2], 1'b1);
        check("odd_out",    out_v[2],   8'h3C);
        check("odd_perr",   perr_v[2],  1'b0);
        check("odd_ferr",   ferr_v[2],  1'b0);
        pulse_rdy();
        check("par_consumed", valid_v[1], 1'b0);

        // Short low pulse is rejected at the start check.
        do_reset();
        wait_ticks(1);
        line = 1'b0;
        wait_ticks(2);
        check("glitch_busy_on", busy_v[0], 1'b1);
        wait_ticks(2);
        line = 1'b1;
        wait_ticks(OS);
        check("glitch_busy_off", busy_v[0], 1'b0);
        check("glitch_no_valid", valid_v[0], 1'b0);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-tick glitch on the centre sample of data bit 2 is outvoted.
        do_reset();
        send_bits(mk8n1(8'h55), 10, 3);
        wait_ticks(8);
        check("vote_valid", valid_v[0], 1'b1);
        check("vote_out",   out_v[0],   8'h55);
        pulse_rdy();
`endif

        // Break: line low 12 bit times.
        do_reset();
        wait_ticks(1);
        line = 1'b0;
        wait_ticks(OS * 11);
        e = '{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
        check_frame("brk", 0, e);
        check("brk_busy", busy_v[0], 1'b0);
        pulse_rdy();
        wait_ticks(OS);
        check("brk_no_restart", busy_v[0], 1'b0);
        line = 1'b1;
        wait_ticks(OS * 2);
        send_bits(mk8n1(8'h5A), 10, -1);
        wait_ticks(8);
        e = '{data: 8'h5A, perr: 1'b0, ferr: 1'b0, brk: 1'b0};
        check_frame("post_brk", 0, e);
        pulse_rdy();

        // Overrun: second frame dropped while first is held.
        do_reset();
        send_bits(mk8n1(8'h11), 10, -1);
        send_bits(mk8n1(8'h22), 10, -1);
        wait_ticks(8);
        check("ovr_valid", valid_v[0], 1'b1);
        check("ovr_out",   out_v[0],   8'h11);
        check("ovr_flag",  ovr_v[0],   1'b1);
        pulse_rdy();
        check("ovr_valid_drop", valid_v[0], 1'b0);
        check("ovr_clear",      ovr_v[0],   1'b0);

        // Completion on the same edge as the handshake.
        send_bits(mk8n1(8'h33), 10, -1);
        wait_ticks(8);
        check("hs_first", out_v[0], 8'h33);
        fork
            send_bits(mk8n1(8'h44), 10, -1);
            begin
                bit seen = 1'b0, hit = 1'b0;
                for (int i = 0; i < 12 * OS * 4; i++) begin
                    @(negedge clk);
                    if (busy_v[0]) seen = 1'b1;
                    else if (seen) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (!hit) check("hs_timeout", 1'b0, 1'b1);
                else begin
                    rdy = 1'b1;
                    @(negedge clk);
                    rdy = 1'b0;
                    check("hs_valid", valid_v[0], 1'b1);
                    check("hs_out",   out_v[0],   8'h44);
                    check("hs_ovr",   ovr_v[0],   1'b0);
                end
            end
        join
        pulse_rdy();

        // Reset during data bit 3 with a frame held.
        do_reset();
        send_bits(mk8n1(8'h5A), 10, -1);
        wait_ticks(8);
        check("pre_rst_valid", valid_v[0], 1'b1);
        fork
            send_bits(mk8n1(8'h07), 10, -1);
            begin
                wait_ticks(1 + OS * 4 + 8);
                #2;
                rstN = 1'b0;
                #1;
                check("mid_rst_valid", valid_v[0], 1'b0);
                check("mid_rst_out",   out_v[0],   8'h00);
                check("mid_rst_busy",  busy_v[0],  1'b0);
                check("mid_rst_ovr",   ovr_v[0],   1'b0);
                @(negedge clk);
                rstN = 1'b1;
                wait_ticks(OS * 2);
                check("rst_no_false_start", busy_v[0], 1'b0);
            end
        join
        wait_ticks(OS * 2);

        // enabled=0 mid-frame drops the frame but keeps the held one.
        send_bits(mk8n1(8'h5A), 10, -1);
        wait_ticks(8);
        fork
            send_bits(mk8n1(8'hC3), 10, -1);
            begin
                wait_ticks(1 + OS * 3);
                check("dis_busy_before", busy_v[0], 1'b1);
                @(negedge clk);
                enabled = 1'b0;
                @(negedge clk);
                check("dis_busy",  busy_v[0],  1'b0);
                check("dis_valid", valid_v[0], 1'b1);
                check("dis_out",   out_v[0],   8'h5A);
                enabled = 1'b1;
            end
        join

        // Random 8N1 frames, occasional bad stop bit and zero data.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            f = {6'h3F, ($urandom_range(0, 3) != 0), d, 1'b0};
            send_bits(f, 10, -1);
            wait_ticks(OS * 2);
            check_frame("rnd_8n1", 0, ref_model(f, 0, 1));
            pulse_rdy();
        end

        // Random parity frames for the even/1-stop and odd/2-stop receivers.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            f = {4'hF, 1'b1, ($urandom_range(0, 3) != 0), 1'($urandom), d, 1'b0};
            send_bits(f, 12, -1);
            wait_ticks(OS * 2);
            check_frame("rnd_8e1", 1, ref_model(f, 1, 1));
            check_frame("rnd_8o2", 2, ref_model(f, 2, 2));
            pulse_rdy();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning s_tick pulses per bit, even, legal 8..64.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none / 1 even / 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1..2.
REQ-005 SHALL have port clk  input  1  sole clock, all flops rising edge.
REQ-006 SHALL have port rstN  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enabled  input  1  receiver enable.
REQ-008 SHALL have port in  input  1  asynchronous rx line, idle high.
REQ-009 SHALL have port s_tick  input  1  one-clk oversample strobe.
REQ-010 SHALL have port rdy  input  1  consumer ready.
REQ-011 SHALL have port valid  output  1  out/flags hold an unconsumed frame.
REQ-012 SHALL have port out  output  DATA_BITS  received data, LSB first on line.
REQ-013 SHALL have port parity_err, frame_err, break_det  output  1 each  per-frame status, qualified by valid.
REQ-014 SHALL have port overrun  output  1  sticky: frame lost because valid was held.
REQ-015 SHALL have port busy  output  1  frame in progress.

Function
REQ-016 SHALL synchronise in through two flops (reset value 1); all references to the line below mean the synchronised value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-018 SHALL count s_tick in a $clog2(OVERSAMPLE)-bit counter s, cleared on each state entry; counter and state advance only on s_tick.
REQ-019 IDLE: SHALL accept a start only when armed (line seen high since last frame); line low while armed -> START, busy=1.
REQ-020 START: at s=OVERSAMPLE/2-1 line high -> IDLE, no flags, no output (glitch reject); line low -> DATA.
REQ-021 DATA/PARITY/STOP: each bit SHALL be sampled at s=OVERSAMPLE-1; DATA shifts LSB first for DATA_BITS bits.
REQ-022 parity_err SHALL be set when XOR(data,parity bit) is 1 for even or 0 for odd; forced 0 when PARITY_MODE=0.
REQ-023 frame_err SHALL be set if any of the STOP_BITS samples is 0; sampling stops after first low stop bit.
REQ-024 break_det SHALL be set when all data bits, the parity bit (if present) and the first stop bit are 0; frame_err also set.
REQ-025 After final stop sample: state->IDLE, busy=0, armed=0; valid SHALL rise on the next clk edge with out and flags (latency 1 clk).
REQ-026 out and flags SHALL stay stable while valid=1; transfer occurs on valid&rdy, valid clears next edge.
REQ-027 Frame completing while valid=1 and rdy=0: new frame discarded, held data kept, overrun=1.
REQ-028 Frame completing on the same edge as valid&rdy: old frame consumed, new frame loaded, valid stays 1, no overrun.
REQ-029 overrun SHALL clear on the next valid&rdy transfer.
REQ-030 enabled=0 SHALL force IDLE, busy=0 and discard partial frame on the next edge; valid, out, flags, overrun unaffected.

Reset
REQ-031 rstN=0 SHALL asynchronously force IDLE, s=0, bit count=0, armed=0, sync flops=1, busy=0, valid=0, out=0, parity_err=0, frame_err=0, break_det=0, overrun=0.
REQ-032 Reset mid-frame SHALL discard the frame; after release a start is accepted only after the line is seen high.

Configuration
REQ-033 Macro UART_RX_MAJORITY_VOTE_EN defined: every sample point (start check, data, parity, stop) SHALL use 2-of-3 majority of line values at s=k-2, k-1, k.
REQ-034 Macro undefined: single sample at s=k; vote logic absent.

Verification
REQ-035 8N1, OVERSAMPLE=16, send 0xA5, rdy=1 -> one valid pulse, out=0xA5, all flags 0, busy high start-detect to last stop sample.
REQ-036 8E1 send 0x3C with parity bit 1 -> out=0x3C, parity_err=1, frame_err=0; odd mode same frame -> parity_err=0.
REQ-037 Line low for 4 ticks then high -> returns IDLE, no valid, busy drops; with macro, single-tick glitch at centre sample inside a 0x55 frame -> out=0x55.
REQ-038 Line held low 12 bit times (8N1) -> valid with out=0x00, frame_err=1, break_det=1; next frame accepted only after line high.
REQ-039 rdy=0, send 0x11 then 0x22 -> out=0x11, overrun=1; raise rdy -> overrun=0, valid drops; completion coinciding with handshake -> 0x22 loaded, overrun=0.
REQ-040 rstN low at DATA bit 3 -> all outputs 0 immediately; enabled=0 mid-frame -> busy=0 next edge, held valid frame retained.
